instr_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the IF stage and instruction memory.
- Returns the 32-bit instruction at the fetch address on a hit, with `valid`=1.
- On a miss it deasserts `valid` and fills a whole 256-bit line when memory presents a valid block.
- IF stalls while `valid`=0; ID uses `valid` as cache-ready.

---
 rtl/instr_cache_pkg.sv | 19 +
 rtl/instr_cache_line_store.sv | 58 +++++
 rtl/instr_cache.sv | 114 +++++++++++
 tb/tb_instr_cache.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package instr_cache_pkg;

  localparam int unsigned LINE_BITS      = 256;
  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned WORDS_PER_LINE = LINE_BITS / WORD_BITS;
  localparam int unsigned OFFSET_W       = 3;
  localparam int unsigned BYTE_OFF_W     = 2;
  localparam int unsigned ADDR_W         = 32;

  // Bits below the index: word offset plus ignored byte offset.
  localparam int unsigned LINE_OFF_W = OFFSET_W + BYTE_OFF_W;

  typedef enum logic {
    READY = 1'b0,
    MISS  = 1'b1
  } state_e;

endpackage

// File: rtl/instr_cache_line_store.sv
// Line storage for the instruction cache: valid/tag/data arrays with one
// combinational read port and one synchronous write port. Only the valid bits
// are reset; tag and data contents are meaningless until their line is valid.
module instr_cache_line_store
  import instr_cache_pkg::*;
#(
  parameter int unsigned NumLines = 32,
  parameter int unsigned IdxW     = 5,
  parameter int unsigned TagW     = 22
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  // Read port
  input  logic [IdxW-1:0]      rd_idx_i,
  output logic                 rd_valid_o,
  output logic [TagW-1:0]      rd_tag_o,
  output logic [LINE_BITS-1:0] rd_data_o,
  // Write port
  input  logic                 we_i,
  input  logic [IdxW-1:0]      wr_idx_i,
  input  logic [TagW-1:0]      wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_data_i
);

  logic [NumLines-1:0] valid_q, valid_d;
  logic [TagW-1:0]      tag_q  [NumLines];
  logic [LINE_BITS-1:0] data_q [NumLines];

  // Valid-bit next state: set the written line's bit on a fill.
  always_comb begin
    valid_d = valid_q;
    if (we_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  // Valid bits, cleared asynchronously so reset drops hits immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data arrays, written on fill only; no reset needed.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

// File: rtl/instr_cache.sv
// Direct-mapped read-only instruction cache between IF and instruction memory.
// Hits return the addressed word combinationally; misses wait for memory to
// present the whole line, which is then written for the address present at
// that edge.
// Optional: define ICACHE_FILL_BYPASS_EN to forward the incoming line word to
// the output during the fill cycle (saves one cycle of miss latency).
module instr_cache
  import instr_cache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [ADDR_W-1:0]    Instr_address_2IC,
  input  logic [LINE_BITS-1:0] block_read_fIC,
  input  logic                 block_read_valid,
  output logic [WORD_BITS-1:0] Instr1_OUT,
  output logic                 valid
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = ADDR_W - LINE_OFF_W - IDX_W;

  if (NUM_LINES < 2 || (NUM_LINES & (NUM_LINES - 1)) != 0) begin : gen_bad_cfg
    $error("instr_cache: NUM_LINES must be a power of two and at least 2");
  end

  // Address split
  logic [OFFSET_W-1:0] offset;
  logic [IDX_W-1:0]    index;
  logic [TAG_W-1:0]    tag;
  logic                unused_byte_off;

  assign offset          = Instr_address_2IC[BYTE_OFF_W +: OFFSET_W];
  assign index           = Instr_address_2IC[LINE_OFF_W +: IDX_W];
  assign tag             = Instr_address_2IC[ADDR_W-1 -: TAG_W];
  assign unused_byte_off = ^Instr_address_2IC[BYTE_OFF_W-1:0];

  // Line store
  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 fill_we;

  instr_cache_line_store #(
    .NumLines (NUM_LINES),
    .IdxW     (IDX_W),
    .TagW     (TAG_W)
  ) u_line_store (
    .clk_i      (CLK),
    .rst_ni     (RESET),
    .rd_idx_i   (index),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we),
    .wr_idx_i   (index),
    .wr_tag_i   (tag),
    .wr_data_i  (block_read_fIC)
  );

  logic hit;
  assign hit = rd_valid && (rd_tag == tag);

  // FSM
  state_e state_q, state_d;

  // Next state and fill strobe. A block arriving while the current address
  // already hits is ignored, so a redirect onto a cached line never rewrites it.
  always_comb begin
    state_d = state_q;
    fill_we = 1'b0;
    unique case (state_q)
      READY: begin
        if (!hit) begin
          if (block_read_valid) begin
            fill_we = 1'b1;
          end else begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        if (block_read_valid) begin
          fill_we = !hit;
          state_d = READY;
        end
      end
      default: state_d = READY;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= READY;
    end else begin
      state_q <= state_d;
    end
  end

  // Output word select; zero whenever the output is not valid.
  always_comb begin
    valid      = hit;
    Instr1_OUT = hit ? rd_data[offset*WORD_BITS +: WORD_BITS] : '0;
`ifdef ICACHE_FILL_BYPASS_EN
    if (!hit && (state_q == MISS) && block_read_valid) begin
      valid      = 1'b1;
      Instr1_OUT = block_read_fIC[offset*WORD_BITS +: WORD_BITS];
    end
`endif
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural cache model.
module tb_instr_cache;

  localparam int NL      = 32;
  localparam int IDX_BITS = $clog2(NL);
`ifdef ICACHE_FILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr;
  logic [255:0] blk;
  logic         brv;
  logic [31:0]  instr;
  logic         vld;

  always #5 clk = ~clk;

  instr_cache #(.NUM_LINES(NL)) dut (
    .CLK               (clk),
    .RESET             (rst_n),
    .Instr_address_2IC (addr),
    .block_read_fIC    (blk),
    .block_read_valid  (brv),
    .Instr1_OUT        (instr),
    .valid             (vld)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: what each line holds, plus whether a miss is pending.
  bit           m_valid [NL];
  int unsigned  m_tag   [NL];
  logic [255:0] m_data  [NL];
  bit           m_pending;

  function automatic int unsigned idx_of(logic [31:0] a);
    return (a >> 5) % NL;
  endfunction

  function automatic int unsigned tag_of(logic [31:0] a);
    return a >> (5 + IDX_BITS);
  endfunction

  function automatic int unsigned off_of(logic [31:0] a);
    return (a >> 2) % 8;
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    return m_valid[idx_of(a)] && (m_tag[idx_of(a)] == tag_of(a));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    m_pending = 1'b0;
  endtask

  always @(negedge rst_n) model_reset();

  // Model update on each active edge using the inputs present at the edge.
  always @(posedge clk) begin : model_upd
    bit h;
    if (rst_n === 1'b1) begin
      h = m_hit(addr);
      if (!h && brv) begin
        m_valid[idx_of(addr)] = 1'b1;
        m_tag[idx_of(addr)]   = tag_of(addr);
        m_data[idx_of(addr)]  = blk;
      end
      if (!m_pending) begin
        if (!h && !brv) m_pending = 1'b1;
      end else if (brv) begin
        m_pending = 1'b0;
      end
    end
  end

  task automatic model_out(output logic ev, output logic [31:0] ei);
    logic [255:0] line;
    ev = 1'b0;
    ei = 32'h0;
    if (m_hit(addr)) begin
      line = m_data[idx_of(addr)];
      ev   = 1'b1;
      ei   = line[off_of(addr)*32 +: 32];
    end else if (BYP && m_pending && brv && rst_n === 1'b1) begin
      ev = 1'b1;
      ei = blk[off_of(addr)*32 +: 32];
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin : compare
    logic        ev;
    logic [31:0] ei;
    if (cmp_en) begin
      model_out(ev, ei);
      n_cmp++;
      if (vld !== ev || instr !== ei) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t addr=%h got valid=%b instr=%h want valid=%b instr=%h",
                 $time, addr, vld, instr, ev, ei);
      end
    end
  end

  task automatic check(input string name, input logic ev, input logic [31:0] ei);
    n_cmp++;
    if (vld !== ev || instr !== ei) begin
      n_bad++;
      $display("FAIL %s t=%0t addr=%h got valid=%b instr=%h want valid=%b instr=%h",
               name, $time, addr, vld, instr, ev, ei);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_block(input logic [31:0] base, input logic [31:0] step);
    for (int w = 0; w < 8; w++) blk[w*32 +: 32] = base + step * w;
  endtask

  initial begin
    model_reset();
    rst_n  = 1'b0;
    addr   = 32'h0040_0000;
    brv    = 1'b0;
    blk    = '0;
    cmp_en = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;

    // Cold miss after reset release.
    for (int i = 0; i < 5; i++) begin
      #1 check("cold_miss", 1'b0, 32'h0);
      tick();
    end

    // Fill 0x00400000 with 0x11111111..0x88888888.
    set_block(32'h1111_1111, 32'h1111_1111);
    brv = 1'b1;
    #1 check("fill_cycle", BYP, BYP ? 32'h1111_1111 : 32'h0);
    tick();
    brv = 1'b0;
    #1 check("hit_word0", 1'b1, 32'h1111_1111);
    addr = 32'h0040_001C;
    #1 check("hit_word7", 1'b1, 32'h8888_8888);
    addr = 32'h0040_0004;
    #1 check("hit_word1", 1'b1, 32'h2222_2222);
    tick();

    // Conflict miss on index 0 with a new tag.
    addr = 32'h0040_0400;
    #1 check("conflict_miss", 1'b0, 32'h0);
    tick();
    set_block(32'hAAAA_0000, 32'h1);
    brv = 1'b1;
    tick();
    brv = 1'b0;
    #1 check("conflict_hit", 1'b1, 32'hAAAA_0000);
    addr = 32'h0040_0000;
    #1 check("evicted", 1'b0, 32'h0);
    tick();

    // Redirect while a miss is pending: block belongs to the new address.
    addr = 32'h0040_0020;
    tick();
    tick();
    addr = 32'h0040_0040;
    set_block(32'hBBBB_0000, 32'h1);
    brv = 1'b1;
    tick();
    brv = 1'b0;
    #1 check("redirect_hit", 1'b1, 32'hBBBB_0000);
    addr = 32'h0040_0020;
    #1 check("redirect_old_miss", 1'b0, 32'h0);
    tick();

    // Asynchronous reset while a miss is pending (address moved onto a hit).
    addr = 32'h0040_0040;
    #1 check("pre_reset_hit", 1'b1, 32'hBBBB_0000);
    rst_n = 1'b0;
    #1 check("reset_in_miss", 1'b0, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1 check("post_reset_40", 1'b0, 32'h0);

    // Immediate fill from READY, then asynchronous reset during a hit.
    addr = 32'h0040_0000;
    set_block(32'h1111_1111, 32'h1111_1111);
    brv = 1'b1;
    tick();
    brv = 1'b0;
    #1 check("ready_fill_hit", 1'b1, 32'h1111_1111);
    rst_n = 1'b0;
    #1 check("reset_in_hit", 1'b0, 32'h0);
    tick();
    rst_n = 1'b1;
    #1 check("post_reset_00", 1'b0, 32'h0);

    // Fill-cycle behaviour on a non-zero offset.
    addr = 32'h0040_0008;
    tick();
    set_block(32'hCCCC_0000, 32'h1);
    brv = 1'b1;
    #1 check("fill_cycle_w2", BYP, BYP ? 32'hCCCC_0002 : 32'h0);
    tick();
    brv = 1'b0;
    #1 check("after_fill_w2", 1'b1, 32'hCCCC_0002);
    tick();

    // Randomized traffic over a small tag/index pool to force hits and conflicts.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) < 45) begin
        addr = {10'h001, 10'($urandom_range(0, 2)), 2'b00, 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00} >> 2 << 2
               | 32'($urandom_range(0, 3));
      end
      brv = ($urandom_range(0, 99) < 30);
      for (int w = 0; w < 8; w++) blk[w*32 +: 32] = $urandom;
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    brv = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
